encoder_ctrl: RTL and testbench

Job sequencer in front of the encoder. Accepts a byte stream from the host, writes it into the encoder input RAM, and holds the encoder chip-select high until the encoder reports done or a watchdog fires. It then reads the output code RAM back and streams the codes to the host. One job is in flight at a time.

---
 rtl/encoder_ctrl_pkg.sv | 22 ++
 rtl/encoder_ctrl_if.sv | 23 ++
 rtl/encoder_ctrl_watchdog.sv | 23 ++
 rtl/encoder_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_encoder_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/encoder_ctrl_pkg.sv
// Shared types and constants for the encoder job sequencer.
package enc_ctrl_pkg;

  // IDLE  | waiting for the first byte of a job
  // LOAD  | writing host bytes into the encoder input RAM
  // FLUSH | input RAM full, discarding bytes until in_last
  // RUN   | encoder selected, waiting for done or watchdog
  // RD    | read strobe to the output code RAM
  // HOLD  | presenting one code to the host
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FLUSH,
    RUN,
    RD,
    HOLD
  } enc_ctrl_state_t;

  localparam int ERR_TRUNC   = 0;
  localparam int ERR_TIMEOUT = 1;

endpackage

// File: rtl/encoder_ctrl_if.sv
// Host-side byte stream (in_*) and code stream (out_*) of the encoder sequencer.
interface encoder_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/encoder_ctrl_watchdog.sv
// RUN-state watchdog: down-counter reloaded by clr, expired pulses on the
// TIMEOUT_CYCLES-th enabled cycle after the last clear.
module enc_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  // Reload while cleared, count down while enabled, park at zero.
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= CW'(TIMEOUT_CYCLES - 1);
    else if (en && cnt != '0) cnt <= cnt - CW'(1);
  end

  assign expired = en && (cnt == '0);
endmodule

// File: rtl/encoder_ctrl.sv
// Encoder job sequencer: loads host bytes into the encoder input RAM, runs the
// encoder under a watchdog, then streams the output codes back to the host.
// Optional build macro ENC_CTRL_PERF_EN adds perf_cycles (RUN cycle count).
module encoder_ctrl
  import enc_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  encoder_ctrl_if.slave         host,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [ADDR_WIDTH:0]   enc_len,
  output logic                  enc_cs,
  input  logic                  enc_done,
  input  logic [ADDR_WIDTH:0]   enc_out_count,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic [1:0]            err
`ifdef ENC_CTRL_PERF_EN
  ,
  output logic [15:0]           perf_cycles
`endif
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  enc_ctrl_state_t       state;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH:0]   out_cnt;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  buf_valid;
  logic                  in_ready_q;
  logic                  wd_expired;
  logic                  accept;
  logic                  write;
  logic                  enter_run;
  logic                  last_code;

  assign accept    = host.in_valid && in_ready_q;
  assign write     = accept && (state == IDLE || state == LOAD);
  // Every path into RUN is the handshake that carries in_last.
  assign enter_run = accept && host.in_last;
  assign last_code = ({1'b0, rd_idx} == out_cnt - (ADDR_WIDTH+1)'(1));

  enc_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state != RUN),
    .en      (state == RUN),
    .expired (wd_expired)
  );

  // Job sequencing FSM with registered in_ready, enc_cs, enc_len and err.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_cnt     <= '0;
      rd_idx     <= '0;
      out_cnt    <= '0;
      enc_len    <= '0;
      enc_cs     <= 1'b0;
      in_ready_q <= 1'b0;
      err        <= '0;
      buf_data   <= '0;
      buf_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            err <= '0;
            if (host.in_last) begin
              enc_len    <= (ADDR_WIDTH+1)'(1);
              enc_cs     <= 1'b1;
              in_ready_q <= 1'b0;
              state      <= RUN;
            end else begin
              wr_cnt <= ADDR_WIDTH'(1);
              state  <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            if (host.in_last) begin
              enc_len    <= {1'b0, wr_cnt} + (ADDR_WIDTH+1)'(1);
              wr_cnt     <= '0;
              enc_cs     <= 1'b1;
              in_ready_q <= 1'b0;
              state      <= RUN;
            end else if (wr_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
              enc_len        <= (ADDR_WIDTH+1)'(DEPTH);
              err[ERR_TRUNC] <= 1'b1;
              wr_cnt         <= '0;
              state          <= FLUSH;
            end else begin
              wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
            end
          end
        end
        FLUSH: begin
          if (accept && host.in_last) begin
            enc_cs     <= 1'b1;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          // done has priority over a watchdog expiry in the same cycle
          if (enc_done) begin
            enc_cs  <= 1'b0;
            out_cnt <= enc_out_count;
            rd_idx  <= '0;
            if (enc_out_count == '0) begin
              in_ready_q <= 1'b1;
              state      <= IDLE;
            end else begin
              state <= RD;
            end
          end else if (wd_expired) begin
            err[ERR_TIMEOUT] <= 1'b1;
            enc_cs           <= 1'b0;
            in_ready_q       <= 1'b1;
            state            <= IDLE;
          end
        end
        RD: begin
          buf_valid <= 1'b0;
          state     <= HOLD;
        end
        HOLD: begin
          // rd_data is only valid on the first HOLD cycle; keep a copy for stalls
          if (!buf_valid) begin
            buf_data  <= rd_data;
            buf_valid <= 1'b1;
          end
          if (host.out_ready) begin
            buf_valid <= 1'b0;
            if (last_code) begin
              in_ready_q <= 1'b1;
              state      <= IDLE;
            end else begin
              rd_idx <= rd_idx + ADDR_WIDTH'(1);
              state  <= RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ENC_CTRL_PERF_EN
  // Cycles spent in RUN for the most recent job, saturating.
  always_ff @(posedge clk) begin
    if (rst || enter_run) perf_cycles <= '0;
    else if (state == RUN && perf_cycles != 16'hFFFF) perf_cycles <= perf_cycles + 16'd1;
  end
`endif

  assign host.in_ready  = in_ready_q;
  assign mem_we         = write;
  assign mem_addr       = write ? wr_cnt : '0;
  assign mem_wdata      = write ? host.in_data : '0;
  assign rd_en          = (state == RD);
  assign rd_addr        = rd_en ? rd_idx : '0;
  assign host.out_valid = (state == HOLD);
  assign host.out_data  = (state != HOLD) ? '0 : (buf_valid ? buf_data : rd_data);
  assign host.out_last  = (state == HOLD) && last_code;
  assign busy           = (state != IDLE);

  // enter_run is only consumed by the optional perf counter
  logic unused_ok;
  assign unused_ok = enter_run;
endmodule

// File: tb/tb_encoder_ctrl.sv
// Self-checking bench for encoder_ctrl: job table, write/code scoreboards,
// and hand sequences for reset-in-RUN and enc_done outside RUN.
module tb_encoder_ctrl;
  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int TO    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  encoder_ctrl_if #(.DATA_WIDTH(DW)) host_if ();

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [AW:0]   enc_len;
  logic          enc_cs;
  logic          enc_done;
  logic [AW:0]   enc_out_count;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          busy;
  logic [1:0]    err;
`ifdef ENC_CTRL_PERF_EN
  logic [15:0]   perf_cycles;
`endif

  encoder_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .host          (host_if),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .enc_len       (enc_len),
    .enc_cs        (enc_cs),
    .enc_done      (enc_done),
    .enc_out_count (enc_out_count),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .busy          (busy),
    .err           (err)
`ifdef ENC_CTRL_PERF_EN
    ,
    .perf_cycles   (perf_cycles)
`endif
  );

  typedef struct {
    int nbytes;
    int count;    // -1: encoder never reports done
    int delay;
    int exp_len;
    int exp_err;
    bit stall;
  } job_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } code_t;

  job_t  jobs[7];
  wr_t   wq[$];
  code_t cq[$];
  wr_t   mon_w;
  code_t mon_c;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] code_ram [DEPTH];
  bit            stall_job  = 1'b0;
  int            beat       = 0;
  int            stall_left = 0;
  logic [DW-1:0] held       = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gen_byte(input int j, input int i);
    if (j == 0) return (i % 2 == 0) ? 8'h41 : 8'h42;
    return 8'(j * 16 + i * 3 + 5);
  endfunction

  // output code RAM: registered read
  always @(posedge clk) if (rd_en) rd_data <= code_ram[rd_addr];

  // host sink + write monitor, sampled 1 time unit after the falling edge
  always begin
    @(negedge clk);
    host_if.out_ready = !(host_if.out_valid && stall_job && beat == 1 && stall_left > 0);
    #1;
    if (mem_we) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=0x%0h", mem_addr, mem_wdata);
      end else begin
        mon_w = wq.pop_front();
        chk("mem_addr", 32'(mem_addr), 32'(mon_w.addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(mon_w.data));
      end
    end
    if (host_if.out_valid && !host_if.out_ready) begin
      if (stall_left == 10) held = host_if.out_data;
      else chk("stall_data", 32'(host_if.out_data), 32'(held));
      chk("stall_rd_en", 32'(rd_en), 32'd0);
      stall_left--;
    end else if (host_if.out_valid && host_if.out_ready) begin
      if (cq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: data=0x%0h", host_if.out_data);
      end else begin
        mon_c = cq.pop_front();
        chk("out_data", 32'(host_if.out_data), 32'(mon_c.data));
        chk("out_last", 32'(host_if.out_last), 32'(mon_c.last));
      end
      beat++;
    end
  end

  // drive the bytes of job j, queueing the RAM writes they should produce
  task automatic send_bytes(input int j);
    int g;
    for (int i = 0; i < jobs[j].nbytes; i++)
      if (i < DEPTH) wq.push_back('{AW'(i), gen_byte(j, i)});
    for (int i = 0; i < jobs[j].nbytes; i++) begin
      @(negedge clk);
      host_if.in_valid = 1'b1;
      host_if.in_data  = gen_byte(j, i);
      host_if.in_last  = (i == jobs[j].nbytes - 1);
      g = 0;
      while (!host_if.in_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (g >= 50) begin
        checks++;
        errors++;
        $display("FAIL in_ready_wait: job %0d byte %0d never accepted", j, i);
      end
      @(posedge clk);
    end
    @(negedge clk);
    host_if.in_valid = 1'b0;
    host_if.in_last  = 1'b0;
  endtask

  task automatic run_job(input int j);
    int g;
    int cs_cycles;
    beat       = 0;
    stall_job  = jobs[j].stall;
    stall_left = jobs[j].stall ? 10 : 0;
    for (int k = 0; k < jobs[j].count; k++) begin
      if (j == 0) begin
        case (k)
          0:       code_ram[k] = 8'h41;
          1:       code_ram[k] = 8'h42;
          default: code_ram[k] = 8'h10;
        endcase
      end else begin
        code_ram[k] = 8'(8'hA0 + j * 7 + k);
      end
      cq.push_back('{code_ram[k], (k == jobs[j].count - 1)});
    end
    send_bytes(j);
    chk("enc_cs_rise", 32'(enc_cs), 32'd1);
    chk("enc_len", 32'(enc_len), 32'(jobs[j].exp_len));
    chk("in_ready_run", 32'(host_if.in_ready), 32'd0);
    chk("writes_done", 32'(wq.size()), 32'd0);
    if (jobs[j].count < 0) begin
      cs_cycles = 0;
      while (enc_cs && cs_cycles < 200) begin
        cs_cycles++;
        @(negedge clk);
      end
      chk("cs_high_cycles", 32'(cs_cycles), 32'(TO));
`ifdef ENC_CTRL_PERF_EN
      chk("perf_cycles", 32'(perf_cycles), 32'(TO));
`endif
    end else begin
      repeat (jobs[j].delay) @(negedge clk);
      chk("cs_before_done", 32'(enc_cs), 32'd1);
      enc_done      = 1'b1;
      enc_out_count = (AW+1)'(jobs[j].count);
      @(negedge clk);
      enc_done      = 1'b0;
      enc_out_count = '1;
      chk("cs_after_done", 32'(enc_cs), 32'd0);
    end
    g = 0;
    while (busy && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (g >= 400) begin
      checks++;
      errors++;
      $display("FAIL job_end_wait: job %0d still busy", j);
    end
    chk("busy_end", 32'(busy), 32'd0);
    chk("err", 32'(err), 32'(jobs[j].exp_err));
    chk("codes_left", 32'(cq.size()), 32'd0);
    chk("in_ready_idle", 32'(host_if.in_ready), 32'd1);
    if (jobs[j].stall) chk("stall_cycles", 32'(stall_left), 32'd0);
    stall_job = 1'b0;
    cq.delete();
    wq.delete();
  endtask

  initial begin
    //          nbytes count delay len err stall
    jobs[0] = '{5,   3,  4, 5,  0, 1'b0};
    jobs[1] = '{20,  2,  2, 16, 1, 1'b0};
    jobs[2] = '{3,  -1,  0, 3,  2, 1'b0};
    jobs[3] = '{2,   0,  3, 2,  0, 1'b0};
    jobs[4] = '{1,   1,  1, 1,  0, 1'b0};
    jobs[5] = '{6,   4,  2, 6,  0, 1'b1};
    jobs[6] = '{16, 16,  5, 16, 0, 1'b0};

    host_if.in_valid  = 1'b0;
    host_if.in_data   = '0;
    host_if.in_last   = 1'b0;
    host_if.out_ready = 1'b1;
    enc_done          = 1'b0;
    enc_out_count     = '0;

    repeat (3) @(negedge clk);
    chk("rst_enc_cs", 32'(enc_cs), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(host_if.in_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out_valid", 32'(host_if.out_valid), 32'd0);
    chk("rst_enc_len", 32'(enc_len), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
`ifdef ENC_CTRL_PERF_EN
    chk("rst_perf", 32'(perf_cycles), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(host_if.in_ready), 32'd1);

    // enc_done in IDLE must not start anything
    enc_done      = 1'b1;
    enc_out_count = 5'd3;
    @(negedge clk);
    enc_done      = 1'b0;
    @(negedge clk);
    chk("done_idle_busy", 32'(busy), 32'd0);
    chk("done_idle_out_valid", 32'(host_if.out_valid), 32'd0);

    for (int j = 0; j < 7; j++) begin
      chk("err_before_job", 32'(err), (j == 0) ? 32'd0 : 32'(jobs[j-1].exp_err));
      run_job(j);
    end

    // reset while the encoder is running
    send_bytes(2);
    repeat (3) @(negedge clk);
    chk("mid_enc_cs", 32'(enc_cs), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_enc_cs", 32'(enc_cs), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_enc_len", 32'(enc_len), 32'd0);
    chk("mid_rst_in_ready", 32'(host_if.in_ready), 32'd0);
    rst = 1'b0;
    wq.delete();
    @(negedge clk);
    run_job(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end
endmodule
